// File: rtl/refr_pkg.sv
// Shared types and helpers for the refresh credit controller.
// Holds the scheduler state encoding and the debt arithmetic.
package refr_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, URGENT, DRAIN} refr_st_e;

    // Unclamped next debt; kept wide so the caller can see a saturation event.
    function automatic int unsigned debt_step(input int unsigned debt,
                                              input int unsigned add,
                                              input logic        sub);
        return debt + add - (sub ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/refr_intv_timer.sv
// Free-running refresh interval counter; pauses while disabled.
// Emits a one-cycle tick on the last count of each interval.
module refr_intv_timer #(
    parameter int unsigned REFRPRD = 64,
    parameter int unsigned BITRPRD = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [BITRPRD-1:0] LAST = BITRPRD'(REFRPRD - 1);

    logic [BITRPRD-1:0] intv_q;

    assign tick = en && (intv_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intv_q <= '0;
        end else if (en) begin
            intv_q <= tick ? '0 : intv_q + BITRPRD'(1);
        end
    end

endmodule

// File: rtl/refr_credit_ctrl.sv
// Refresh credit scheduler: turns interval ticks into per-bank refresh debt,
// gates the refresh engine and escalates to a pipeline stall when behind.
module refr_credit_ctrl
    import refr_pkg::*;
#(
    parameter int unsigned NUMRBNK  = 4,
    parameter int unsigned BITRBNK  = 2,
    parameter int unsigned REFRPRD  = 64,
    parameter int unsigned BITRPRD  = 6,
    parameter int unsigned MAXDEBT  = 12,
    parameter int unsigned BITDEBT  = 4,
    parameter int unsigned HIDEBT   = 8,
    parameter int unsigned LODEBT   = 2,
    parameter int unsigned STUCKLIM = 16,
    parameter int unsigned BITSTUCK = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               refr_en,
    input  logic               prefr,
    input  logic [BITRBNK-1:0] prfbadr,
    input  logic               phigh,
    output logic               norefr,
    output logic               refr_stall,
    output logic [BITDEBT-1:0] refr_debt,
    output logic               refr_done,
    output logic               refr_ovfl,
    output logic               refr_perr
);

    refr_st_e            state_q;
    logic [BITDEBT-1:0]  debt_q, debt_d;
    logic [BITSTUCK-1:0] stuck_q, stuck_d;
    logic [BITRBNK-1:0]  rnd_q;
    logic                done_q, ovfl_q, perr_q;
    logic                tick, pref_cnt, clamp, rnd_wrap, debt_hi, debt_lo, stuck_hit;
    int unsigned         debt_sum;

    // Bank address is owned by the engine; only the refresh strobe matters here.
    logic unused_prfbadr;
    assign unused_prfbadr = ^prfbadr;

    refr_intv_timer #(
        .REFRPRD (REFRPRD),
        .BITRPRD (BITRPRD)
    ) u_intv_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (refr_en),
        .tick  (tick)
    );

    assign pref_cnt = prefr && (debt_q != '0);
    assign rnd_wrap = pref_cnt && (rnd_q == BITRBNK'(NUMRBNK - 1));

    always_comb begin
        debt_sum = debt_step(32'(debt_q), tick ? NUMRBNK : 32'd0, pref_cnt);
        clamp    = debt_sum > MAXDEBT;
        debt_d   = clamp ? BITDEBT'(MAXDEBT) : BITDEBT'(debt_sum);
        stuck_d  = '0;
        if (phigh) begin
            stuck_d = (stuck_q == BITSTUCK'(STUCKLIM)) ? stuck_q : stuck_q + BITSTUCK'(1);
        end
    end

    // Transitions look at next-cycle debt/stuck so escalation is not a cycle late.
    assign debt_hi   = debt_d >= BITDEBT'(HIDEBT);
    assign debt_lo   = debt_d <= BITDEBT'(LODEBT);
    assign stuck_hit = stuck_d == BITSTUCK'(STUCKLIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            debt_q  <= '0;
            stuck_q <= '0;
            rnd_q   <= '0;
            done_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            debt_q  <= debt_d;
            stuck_q <= stuck_d;
            done_q  <= rnd_wrap;
            if (pref_cnt) rnd_q <= rnd_wrap ? '0 : rnd_q + BITRBNK'(1);
            if (clamp) ovfl_q <= 1'b1;
            if (prefr && (debt_q == '0)) perr_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (refr_en) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (debt_hi || stuck_hit) state_q <= URGENT;
                    else if (!refr_en)        state_q <= (debt_d != '0) ? DRAIN : IDLE;
                end
                URGENT: begin
                    if (debt_lo && !phigh) begin
                        if (refr_en)              state_q <= ACTIVE;
                        else if (debt_d != '0)    state_q <= DRAIN;
                        else                      state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (debt_hi || stuck_hit) state_q <= URGENT;
                    else if (refr_en)         state_q <= ACTIVE;
                    else if (debt_d == '0)    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign norefr     = (state_q == IDLE) || ((debt_q == '0) && !phigh);
    assign refr_stall = (state_q == URGENT);
    assign refr_debt  = debt_q;
    assign refr_done  = done_q;
    assign refr_ovfl  = ovfl_q;
    assign refr_perr  = perr_q;

endmodule

// File: tb/tb_refr_credit_ctrl.sv
// Directed bench for refr_credit_ctrl with hand-computed expectations.
module tb_refr_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       refr_en, prefr, phigh;
    logic [1:0] prfbadr;
    logic       norefr, refr_stall, refr_done, refr_ovfl, refr_perr;
    logic [3:0] refr_debt;

    int nvec = 0;
    int nmis = 0;
    int ecnt = 0;  // enabled clock edges since reset; ticks land on multiples of 64

    always #5 clk = ~clk;

    refr_credit_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .refr_en    (refr_en),
        .prefr      (prefr),
        .prfbadr    (prfbadr),
        .phigh      (phigh),
        .norefr     (norefr),
        .refr_stall (refr_stall),
        .refr_debt  (refr_debt),
        .refr_done  (refr_done),
        .refr_ovfl  (refr_ovfl),
        .refr_perr  (refr_perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (refr_en) ecnt++;
        #1;
        prfbadr = prfbadr + 2'd1;
    endtask

    task automatic run_to(input int target);
        while (ecnt < target) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; refr_en = 1'b0; prefr = 1'b0; phigh = 1'b0; prfbadr = 2'd0;
        #12;
        chk("rst_debt",   refr_debt, 0);
        chk("rst_norefr", norefr, 1);
        chk("rst_stall",  refr_stall, 0);
        chk("rst_done",   refr_done, 0);
        chk("rst_ovfl",   refr_ovfl, 0);
        chk("rst_perr",   refr_perr, 0);
        rst_n = 1'b1; refr_en = 1'b1;

        // 1: first interval
        run_to(63);
        chk("t1_debt_pre",   refr_debt, 0);
        chk("t1_norefr_pre", norefr, 1);
        run_to(64);
        chk("t1_debt",   refr_debt, 4);
        chk("t1_norefr", norefr, 0);
        chk("t1_stall",  refr_stall, 0);

        // 2: drain one round
        prefr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_debt", refr_debt, 32'(3 - i));
            chk("t2_done", refr_done, (i == 3) ? 32'd1 : 32'd0);
        end
        prefr = 1'b0;
        chk("t2_norefr", norefr, 1);
        step();
        chk("t2_done_clr", refr_done, 0);

        // 3: tick and prefr net out
        run_to(128);
        chk("t3_debt_tick", refr_debt, 4);
        prefr = 1'b1; step(); prefr = 1'b0;
        chk("t3_debt3", refr_debt, 3);
        run_to(191);
        prefr = 1'b1; step(); prefr = 1'b0;
        chk("t3_debt_net", refr_debt, 6);
        chk("t3_ovfl", refr_ovfl, 0);
        prefr = 1'b1;
        repeat (6) step();
        prefr = 1'b0;
        chk("t3_debt_zero", refr_debt, 0);

        // 4: accumulate, escalate, saturate, recover
        run_to(256);
        chk("t4_debt4", refr_debt, 4);
        chk("t4_stall4", refr_stall, 0);
        run_to(320);
        chk("t4_debt8", refr_debt, 8);
        chk("t4_stall8", refr_stall, 1);
        run_to(384);
        chk("t4_debt12", refr_debt, 12);
        chk("t4_ovfl12", refr_ovfl, 0);
        run_to(448);
        chk("t4_debt_sat", refr_debt, 12);
        chk("t4_ovfl_sat", refr_ovfl, 1);
        prefr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_debt_dn", refr_debt, 32'(11 - i));
            chk("t4_stall_dn", refr_stall, (i < 9) ? 32'd1 : 32'd0);
        end
        prefr = 1'b0;

        // 5: stuck bank escalation
        prefr = 1'b1; step(); prefr = 1'b0;
        chk("t5_debt1", refr_debt, 1);
        phigh = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t5_stall_stuck", refr_stall, (i == 15) ? 32'd1 : 32'd0);
        end
        phigh = 1'b0;
        step();
        chk("t5_stall_exit", refr_stall, 0);
        chk("t5_debt_hold", refr_debt, 1);

        // 6: drain with scheduling disabled
        run_to(512);
        chk("t6_debt5", refr_debt, 5);
        prefr = 1'b1; repeat (2) step(); prefr = 1'b0;
        chk("t6_debt3", refr_debt, 3);
        chk("t6_perr_pre", refr_perr, 0);
        refr_en = 1'b0;
        step();
        chk("t6_norefr_drain", norefr, 0);
        chk("t6_stall_drain", refr_stall, 0);
        prefr = 1'b1; repeat (3) step(); prefr = 1'b0;
        chk("t6_debt0", refr_debt, 0);
        chk("t6_norefr_idle", norefr, 1);
        phigh = 1'b1; #1;
        chk("t6_norefr_idle_phigh", norefr, 1);
        phigh = 1'b0;
        prefr = 1'b1; step(); prefr = 1'b0;
        chk("t6_perr", refr_perr, 1);
        chk("t6_debt_perr", refr_debt, 0);

        // Re-enter URGENT via stuck bank, then async reset
        refr_en = 1'b1; phigh = 1'b1;
        repeat (16) step();
        chk("t6_urgent", refr_stall, 1);
        chk("t6_norefr_urgent", norefr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall",  refr_stall, 0);
        chk("arst_norefr", norefr, 1);
        chk("arst_debt",   refr_debt, 0);
        chk("arst_ovfl",   refr_ovfl, 0);
        chk("arst_perr",   refr_perr, 0);
        chk("arst_done",   refr_done, 0);
        phigh = 1'b0; refr_en = 1'b0;
        #10 rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
